ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares port A of the 2048x32 block RAM between two bus requesters: m0 (CPU data path) and m1 (boot loader / DMA).
- Round-robin arbitration.
- One access in flight at a time.
- Fixed four-cycle request-to-ack sequence, built around the RAM's one-cycle registered read.
- Sits between the bus masters and the RAM. Port B (instruction fetch) is not touched.

Parameters:
- ADDR_W, 11, word-address width into the RAM.
- DATA_W, 32, data width.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 access request; held high until m0_ack.
- m0_we  in  1  1 = write, 0 = read; valid while m0_req.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_rdata  out  DATA_W  read data; valid while m0_ack.
- m0_ack  out  1  one-cycle completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as m0, for requester 1.
- ram_en  out  1  RAM port A enable.
- ram_we  out  1  RAM port A write enable.
- ram_addr  out  ADDR_W  RAM port A address.
- ram_wdata  out  DATA_W  RAM port A write data.
- ram_rdata  in  DATA_W  RAM port A output; registered in RAM, valid the cycle after ram_en.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, m0/m1_rdata=0, m0/m1_ack=0, busy=0, last=1 (so m0 wins the first tie).
- States: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester != last.
  - On grant: latch sel, and latch we/addr/wdata into ram_we/ram_addr/ram_wdata; set ram_en=1; go to ISSUE; last <= sel.
- ISSUE: ram_en high for exactly this cycle; RAM samples at its end. Next: ram_en=0, ram_we=0, go to CAPTURE.
- CAPTURE: ram_rdata is valid. Register it into m<sel>_rdata and set m<sel>_ack=1; go to DONE.
- DONE:
  - m<sel>_ack high for this cycle only; it clears on exit.
  - m<sel>_rdata holds its value until the next access by that requester.
  - Go to IDLE.
- Latency: req sampled at edge of cycle 0; ram_en high in cycle 1; ack high in cycle 3; next arbitration in cycle 4.
- Throughput: one access per 4 cycles.
- Requester rule: after seeing ack, the requester must drop req in the following cycle or present a new request. IDLE in cycle 4 treats a high req as a new request.
- Non-granted requester: its req is simply held; it is not sampled until the next IDLE.
  - With both requesters continuously requesting, grants strictly alternate.
  - Worst-case wait is 8 cycles.
- Writes: the RAM is read-first, so m<sel>_rdata returns the word's previous contents on a write. Writes still ack.
- Request inputs are ignored outside IDLE. Changes to the granted requester's addr/wdata/we after the grant have no effect.
- Reset asserted in any state returns to the reset values on the next edge.
  - An in-flight access is abandoned with no ack.
  - An ISSUE-cycle write may already have landed in the RAM; this is acceptable.
- Addresses are word-indexed, ADDR_W bits; no range checking. Byte-address conversion is the requester's job.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_CAPTURE=2'd2, ST_DONE=2'd3) and the ADDR_W/DATA_W defaults.
- One natural sub-module, rr_arbiter2: combinational two-way round-robin pick. Inputs req[1:0] and last; outputs grant_valid and sel. It is reusable for other shared slaves.
- The FSM and datapath registers stay in ram_port_arbiter.

Test Plan:
- Single write then read: m0 writes 32'hDEADBEEF to 11'h010 (m0_req at cycle 0).
  - ram_en/ram_we high in cycle 1 with addr 11'h010; m0_ack in cycle 3.
  - m0 then reads 11'h010 -> m0_rdata=32'hDEADBEEF with m0_ack 3 cycles after its req sample.
- Simultaneous first requests after reset: m0 reads 11'h001, m1 reads 11'h002 in the same cycle.
  - m0 is granted first (ack cycle 3); m1 acks at cycle 7; busy stays high cycles 1-3 and 5-7.
- Sustained contention: both req held high for 6 accesses.
  - Grant order is m0, m1, m0, m1, m0, m1.
  - Each ack goes to the correct requester; the other ack stays 0.
- Read-first on write: preload 11'h7FF=32'h12345678, then m1 writes 32'h0 there.
  - m1_rdata=32'h12345678 at ack; a subsequent read returns 32'h0.
- Reset mid-operation: assert rst during CAPTURE of an m0 read.
  - No m0_ack is ever produced; state returns to IDLE; all outputs are at reset values next cycle.
  - The next simultaneous request grants m0 first.
- Input stability: change m0_addr from 11'h020 to 11'h030 during ISSUE.
  - The RAM sees 11'h020 only; returned data matches 11'h020.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port-A arbiter: state encoding and
// default geometry of the 2048x32 RAM.
package ram_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone request wins outright, a tie
// goes to the requester that was not granted last.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       sel
);

   always_comb begin
      grant_valid = |req;
      sel         = 1'b0;
      case (req)
         2'b01:   sel = 1'b0;
         2'b10:   sel = 1'b1;
         2'b11:   sel = ~last;
         default: sel = 1'b0;
      endcase
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between two bus requesters with round-robin arbitration
// and a fixed four-cycle request-to-ack sequence; all outputs registered.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   state_t state;
   logic   sel;
   logic   last;
   logic   arb_valid;
   logic   arb_sel;

   rr_arbiter2 u_rr (
      .req         ({m1_req, m0_req}),
      .last        (last),
      .grant_valid (arb_valid),
      .sel         (arb_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sel       <= 1'b0;
         last      <= 1'b1;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            // Arbitrate and latch the winner's command; later changes on its
            // inputs are ignored until the next IDLE.
            ST_IDLE: begin
               if (arb_valid) begin
                  sel       <= arb_sel;
                  last      <= arb_sel;
                  ram_en    <= 1'b1;
                  ram_we    <= arb_sel ? m1_we    : m0_we;
                  ram_addr  <= arb_sel ? m1_addr  : m0_addr;
                  ram_wdata <= arb_sel ? m1_wdata : m0_wdata;
                  busy      <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            // RAM samples the command at the end of this cycle.
            ST_ISSUE: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               state  <= ST_CAPTURE;
            end
            // Registered RAM output is valid now; hand it to the owner.
            ST_CAPTURE: begin
               if (sel) begin
                  m1_rdata <= ram_rdata;
                  m1_ack   <= 1'b1;
               end else begin
                  m0_rdata <= ram_rdata;
                  m0_ack   <= 1'b1;
               end
               state <= ST_DONE;
            end
            // Ack is visible for this single cycle.
            ST_DONE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
